// File: rtl/y_signature_capture_pkg.sv
// Shared types, default widths/constants and the y-bus fold used by the
// signature capture block and the differential-compare side.
package sig_capture_pkg;

    localparam int unsigned Y_W   = 47;
    localparam int unsigned SIG_W = 32;
    localparam int unsigned CNT_W = 16;
    localparam logic [SIG_W-1:0] POLY = 32'h04C11DB7;
    localparam logic [SIG_W-1:0] SEED = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cap_state_t;

    // Upper y bits are XORed onto the low end of the signature word.
    function automatic logic [SIG_W-1:0] fold_y(input logic [Y_W-1:0] y);
        return y[SIG_W-1:0] ^ SIG_W'(y[Y_W-1:SIG_W]);
    endfunction

endpackage

// File: rtl/y_signature_capture_if.sv
// Capture request / result handshake bundle between the y consumer and its
// controller; master drives requests, slave is the capture block.
interface y_signature_capture_if
    import sig_capture_pkg::*;
#(
    parameter int unsigned Y_W   = sig_capture_pkg::Y_W,
    parameter int unsigned SIG_W = sig_capture_pkg::SIG_W,
    parameter int unsigned CNT_W = sig_capture_pkg::CNT_W
);
    logic             start;
    logic [CNT_W-1:0] num_cycles;
    logic [Y_W-1:0]   y_in;
    logic             busy;
    logic             sig_valid;
    logic             sig_ready;
    logic [SIG_W-1:0] sig_out;
    logic [CNT_W-1:0] toggle_cnt;

    modport master (
        output start, num_cycles, y_in, sig_ready,
        input  busy, sig_valid, sig_out, toggle_cnt
    );

    modport slave (
        input  start, num_cycles, y_in, sig_ready,
        output busy, sig_valid, sig_out, toggle_cnt
    );

endinterface

// File: rtl/y_signature_capture_misr_step.sv
// One MISR compaction step: shift left, feed back POLY on MSB, XOR in the
// folded sample. Purely combinational so the compare side can reuse it.
module misr_step
    import sig_capture_pkg::*;
#(
    parameter int unsigned       SIG_W = sig_capture_pkg::SIG_W,
    parameter logic [SIG_W-1:0]  POLY  = sig_capture_pkg::POLY
) (
    input  logic [SIG_W-1:0] sig,
    input  logic [SIG_W-1:0] fold,
    output logic [SIG_W-1:0] sig_next
);

    always_comb begin
        sig_next = {sig[SIG_W-2:0], 1'b0} ^ fold;
        if (sig[SIG_W-1])
            sig_next = sig_next ^ POLY;
    end

endmodule

// File: rtl/y_signature_capture.sv
// Windowed MISR signature and toggle counter over the y result bus, with the
// result offered through a valid/ready handshake.
module y_signature_capture
    import sig_capture_pkg::*;
#(
    parameter int unsigned      Y_W   = sig_capture_pkg::Y_W,
    parameter int unsigned      SIG_W = sig_capture_pkg::SIG_W,
    parameter int unsigned      CNT_W = sig_capture_pkg::CNT_W,
    parameter logic [SIG_W-1:0] POLY  = sig_capture_pkg::POLY,
    parameter logic [SIG_W-1:0] SEED  = sig_capture_pkg::SEED
) (
    input  logic                  clk,
    input  logic                  rst_n,
    y_signature_capture_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    cap_state_t       state;
    logic [SIG_W-1:0] sig;
    logic [SIG_W-1:0] sig_next;
    logic [SIG_W-1:0] fold;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] toggles;
    logic [Y_W-1:0]   prev;
    logic             busy_q;
    logic             valid_q;

    assign fold = bus.y_in[SIG_W-1:0] ^ SIG_W'(bus.y_in[Y_W-1:SIG_W]);

    misr_step #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_misr_step (
        .sig      (sig),
        .fold     (fold),
        .sig_next (sig_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            sig     <= '0;
            toggles <= '0;
            cnt     <= '0;
            prev    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sig     <= SEED;
                        cnt     <= bus.num_cycles;
                        prev    <= '0;
                        toggles <= '0;
                        busy_q  <= 1'b1;
                        if (bus.num_cycles != '0) begin
                            state <= RUN;
                        end else begin
                            state   <= DONE;
                            valid_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    sig  <= sig_next;
                    prev <= bus.y_in;
                    cnt  <= cnt - CNT_ONE;
                    if (bus.y_in != prev && toggles != '1)
                        toggles <= toggles + CNT_ONE;
                    // cnt==1 here means this edge consumes the final sample.
                    if (cnt == CNT_ONE) begin
                        state   <= DONE;
                        valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.sig_ready) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.sig_valid  = valid_q;
    assign bus.sig_out    = sig;
    assign bus.toggle_cnt = toggles;

endmodule

// File: tb/tb_y_signature_capture.sv
// Directed bench for y_signature_capture: table of short capture windows plus
// hand sequences for hold-in-DONE, mid-window reset and the longest window.
module tb_y_signature_capture;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    y_signature_capture_if bus ();

    y_signature_capture dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]      n;
        logic [3:0][46:0] ys;
        logic [31:0]      exp_sig;
        logic [15:0]      exp_tog;
        logic             start_in_run;
    } vec_t;

    vec_t        vecs [6];
    logic [46:0] yq   [16];

    function automatic logic [31:0] m_step(input logic [31:0] s, input logic [46:0] y);
        logic [31:0] f;
        f = y[31:0] ^ {17'b0, y[46:32]};
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
    endfunction

    function automatic vec_t mk(input logic [15:0] n, input logic [46:0] a, input logic [46:0] b,
                                input logic [46:0] c, input logic [46:0] d,
                                input logic [31:0] s, input logic [15:0] t, input logic sir);
        vec_t v;
        v.n = n;
        v.ys[0] = a; v.ys[1] = b; v.ys[2] = c; v.ys[3] = d;
        v.exp_sig = s;
        v.exp_tog = t;
        v.start_in_run = sir;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Runs one window using yq[0..n-1], checks the result and releases it.
    task automatic run_short(input int n, input logic [31:0] exp_sig, input logic [15:0] exp_tog,
                             input logic sir, input string nm);
        bus.start      = 1'b1;
        bus.num_cycles = 16'(n);
        tick();
        bus.start      = sir;
        bus.num_cycles = 16'd7;
        if (n > 0) begin
            check({nm, " busy@start"}, 64'(bus.busy), 64'd1);
            check({nm, " valid@start"}, 64'(bus.sig_valid), 64'd0);
        end
        for (int i = 0; i < n; i++) begin
            bus.y_in = yq[i];
            tick();
            if (i < n - 1)
                check({nm, " valid early"}, 64'(bus.sig_valid), 64'd0);
        end
        bus.start = 1'b0;
        check({nm, " valid"}, 64'(bus.sig_valid), 64'd1);
        check({nm, " busy"}, 64'(bus.busy), 64'd1);
        check({nm, " sig"}, 64'(bus.sig_out), 64'(exp_sig));
        check({nm, " tog"}, 64'(bus.toggle_cnt), 64'(exp_tog));
        bus.sig_ready = 1'b1;
        tick();
        bus.sig_ready = 1'b0;
        check({nm, " busy@rel"}, 64'(bus.busy), 64'd0);
        check({nm, " valid@rel"}, 64'(bus.sig_valid), 64'd0);
        check({nm, " sig@rel"}, 64'(bus.sig_out), 64'(exp_sig));
        check({nm, " tog@rel"}, 64'(bus.toggle_cnt), 64'(exp_tog));
    endtask

    initial begin
        logic [31:0] ms;
        logic [31:0] held_sig;
        logic [15:0] mt;
        logic [46:0] py;
        logic [46:0] b40;

        n_cmp = 0;
        n_bad = 0;
        b40 = '0;
        b40[40] = 1'b1;

        vecs[0] = mk(16'd1, 47'd0, 47'd0, 47'd0, 47'd0, 32'hFB3EE249, 16'd0, 1'b0);
        vecs[1] = mk(16'd0, 47'd0, 47'd0, 47'd0, 47'd0, 32'hFFFFFFFF, 16'd0, 1'b0);
        vecs[2] = mk(16'd1, b40,   47'd0, 47'd0, 47'd0, 32'hFB3EE349, 16'd1, 1'b0);
        vecs[3] = mk(16'd4, 47'd0, 47'd1, 47'd0, 47'd1, 32'hC7B04248, 16'd3, 1'b0);
        vecs[4] = mk(16'd1, 47'd1, 47'd0, 47'd0, 47'd0, 32'hFB3EE248, 16'd1, 1'b0);
        vecs[5] = mk(16'd3, 47'd0, 47'd0, 47'd0, 47'd0, 32'hE1B8AFFD, 16'd0, 1'b1);

        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.num_cycles = '0;
        bus.y_in = '0;
        bus.sig_ready = 1'b0;
        tick();
        tick();
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst valid", 64'(bus.sig_valid), 64'd0);
        check("rst sig", 64'(bus.sig_out), 64'd0);
        check("rst tog", 64'(bus.toggle_cnt), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < 4; k++) yq[k] = vecs[v].ys[k];
            run_short(int'(vecs[v].n), vecs[v].exp_sig, vecs[v].exp_tog,
                      vecs[v].start_in_run, $sformatf("vec%0d", v));
        end

        // Hold in DONE: y_in and start must not disturb the result.
        bus.start = 1'b1;
        bus.num_cycles = 16'd1;
        tick();
        bus.start = 1'b0;
        bus.y_in = '0;
        tick();
        for (int c = 0; c < 5; c++) begin
            bus.y_in = 47'(c * 47'h123456789) ^ 47'h7FFF_0000_0000;
            bus.start = c[0];
            bus.num_cycles = 16'd3;
            tick();
            check("hold valid", 64'(bus.sig_valid), 64'd1);
            check("hold sig", 64'(bus.sig_out), 64'h00000000FB3EE249);
            check("hold tog", 64'(bus.toggle_cnt), 64'd0);
        end
        bus.sig_ready = 1'b1;
        bus.start = 1'b1;
        bus.num_cycles = 16'd0;
        tick();
        bus.sig_ready = 1'b0;
        check("ready+start busy", 64'(bus.busy), 64'd0);
        check("ready+start valid", 64'(bus.sig_valid), 64'd0);
        tick();
        bus.start = 1'b0;
        check("restart valid", 64'(bus.sig_valid), 64'd1);
        check("restart sig", 64'(bus.sig_out), 64'h00000000FFFFFFFF);
        bus.sig_ready = 1'b1;
        tick();
        bus.sig_ready = 1'b0;

        // Reset on the 5th RUN cycle of a 10-cycle window, then rerun cleanly.
        for (int i = 0; i < 10; i++) yq[i] = {15'(i + 2), 32'(i * 32'h01010101)};
        ms = 32'hFFFFFFFF;
        mt = '0;
        py = '0;
        for (int i = 0; i < 10; i++) begin
            ms = m_step(ms, yq[i]);
            if (yq[i] != py) mt++;
            py = yq[i];
        end
        bus.start = 1'b1;
        bus.num_cycles = 16'd10;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.y_in = yq[i];
            tick();
        end
        rst_n = 1'b0;
        bus.y_in = yq[4];
        tick();
        rst_n = 1'b1;
        check("midrst busy", 64'(bus.busy), 64'd0);
        check("midrst valid", 64'(bus.sig_valid), 64'd0);
        check("midrst sig", 64'(bus.sig_out), 64'd0);
        check("midrst tog", 64'(bus.toggle_cnt), 64'd0);
        tick();
        check("post-rst idle busy", 64'(bus.busy), 64'd0);
        run_short(10, ms, mt, 1'b0, "rerun");

        // Longest window: alternating y toggles every sample.
        ms = 32'hFFFFFFFF;
        bus.start = 1'b1;
        bus.num_cycles = 16'hFFFF;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            bus.y_in = (i % 2 == 0) ? 47'h4000_0000_0001 : 47'd0;
            ms = m_step(ms, bus.y_in);
            tick();
            if (i == 65533)
                check("max valid early", 64'(bus.sig_valid), 64'd0);
        end
        check("max valid", 64'(bus.sig_valid), 64'd1);
        check("max sig", 64'(bus.sig_out), 64'(ms));
        check("max tog", 64'(bus.toggle_cnt), 64'hFFFF);
        held_sig = bus.sig_out;
        bus.sig_ready = 1'b1;
        tick();
        bus.sig_ready = 1'b0;
        check("max rel busy", 64'(bus.busy), 64'd0);
        check("max rel sig", 64'(bus.sig_out), 64'(ms));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
